vm2002_coin_acceptor: RTL
=========================

// Module: vm2002_coin_acceptor
// PURPOSE
//  Coin front end that sits directly upstream of vm2002 and feeds its amount input.
//  - Samples the per-cycle coin code, converts it to cents and accumulates a credit.
//  - Rejects any coin that would exceed MAX_AMOUNT.
//  - Runs an inactivity timer.
//  - Hands the credit to vm2002 on done, or refunds it on soft reset or timeout.
// PARAMETERS
//  MAX_AMOUNT      255  largest credit held, in cents; must fit in 8 bits
//  TIMEOUT_CYCLES  100  idle cycles in COLLECT before auto-refund; must be >= 1
//  VAL_C1          5    cents for coin code 2'b01
//  VAL_C2          10   cents for coin code 2'b10
//  VAL_C3          25   cents for coin code 2'b11
// PORTS
//  clk            in   1  system clock, rising edge
//  hrst_n         in   1  hard reset, asynchronous, active-low
//  srst           in   1  soft reset / cancel, synchronous, active-high
//  insert_coins   in   1  from vm2002: coin entry enabled (level)
//  coins          in   2  coin code: 00 none, 01/10/11 = C1/C2/C3; one coin per cycle when nonzero
//  done           in   1  from vm2002: credit consumed (1-cycle pulse)
//  amount         out  8  current credit in cents, to vm2002
//  coin_accept    out  1  pulse: coin sampled last cycle was added
//  coin_reject    out  1  pulse: coin sampled last cycle was returned
//  refund         out  1  pulse: credit returned to customer
//  refund_amount  out  8  credit returned; valid while refund=1, else 0
//  timeout        out  1  pulse: inactivity timer expired
// BEHAVIOUR
//  Reset
//  - hrst_n low forces: state=IDLE, amount=0, idle counter=0, all pulse outputs=0, refund_amount=0.
//  - Takes effect immediately, including mid-collection; the credit is lost (no refund pulse).
//  Registered outputs
//  - All outputs are registered.
//  - Coin sampled at edge N: amount and coin_accept/coin_reject are updated after edge N, so they are visible in cycle N+1.
//  State IDLE
//  - amount=0.
//  - A nonzero coin -> coin_reject.
//  - insert_coins=1 -> COLLECT; a coin in that same cycle is rejected.
//  State COLLECT
//  - Event priority per cycle: srst > done > timer expiry > coin.
//  - srst: amount>0 -> REFUND; amount=0 -> IDLE. A coin in the same cycle is rejected.
//  - done: amount<=0, go to IDLE, no refund. A coin in the same cycle is rejected.
//  - Timer: the idle counter increments each cycle without an accepted coin and clears on an accepted coin.
//  - Expiry: when the counter reaches TIMEOUT_CYCLES-1 and no coin is accepted that cycle:
//    - timeout=1 for one cycle;
//    - amount>0 -> REFUND, else IDLE;
//    - the counter clears.
//  - Coin with insert_coins=1:
//    - amount+value <= MAX_AMOUNT -> amount+=value, coin_accept;
//    - otherwise -> coin_reject, amount unchanged.
//    - amount+value == MAX_AMOUNT is accepted.
//  - Coin with insert_coins=0: rejected. The state stays COLLECT and the timer keeps running.
//  State REFUND (lasts exactly one cycle)
//  - refund=1, refund_amount=credit, amount=0.
//  - Any coin is rejected.
//  - Next state is IDLE regardless of inputs.
//  Arithmetic
//  - The sum is computed 9 bits wide, so there is no 8-bit wrap.
//  - amount never exceeds MAX_AMOUNT.
//  - coin_accept and coin_reject are never both 1.
//  Idle and reserved values
//  - coins=00 produces no pulse.
//  - No reserved coin codes.
// TESTING
//  T1 Reset and idle coins
//   - hrst_n low 10 cycles, then coins=01 in IDLE -> amount=0, coin_reject=1 next cycle.
//  T2 Accumulate and hand off
//   - insert_coins=1, coins 01,10,11 on consecutive cycles -> amount 5,15,40; three coin_accept pulses.
//   - Then done -> amount=0, state IDLE, refund=0.
//  T3 Saturation
//   - Reach amount=250, then coin 01 -> amount 255, accept.
//   - Then coin 01 -> reject, amount stays 255.
//   - From 240, coin 11 -> reject, amount 240.
//  T4 Timeout refund (TIMEOUT_CYCLES=100)
//   - amount=40, no coins -> timeout then refund, refund_amount=40, amount=0.
//   - Timing: timeout at edge 100 after the last accept, refund on the following edge.
//   - Also: a coin accepted at cycle 99 restarts the count.
//  T5 Cancel and simultaneous events
//   - amount=25, srst with coin 11 -> reject, refund_amount=25.
//   - done with srst -> refund wins.
//   - done with coin -> coin rejected, amount=0, no refund.
//  T6 Async reset mid-operation
//   - amount=100, pulse hrst_n low between edges -> amount=0 immediately, no refund pulse, state IDLE.

Source files
------------

// File: rtl/vm2002_coin_acceptor.sv
// vm2002_coin_acceptor
// Coin front end that sits directly upstream of vm2002 and feeds its amount
// input. Each nonzero coin code is converted to cents and added to a running
// credit, unless that would push the credit past MAX_AMOUNT. An inactivity
// timer refunds an abandoned credit. vm2002 either consumes the credit (done)
// or the customer cancels it (srst), which returns the credit through a
// one-cycle refund pulse.
//
// Ports
//   clk            in   system clock, rising edge
//   hrst_n         in   hard reset, asynchronous, active-low
//   srst           in   soft reset / cancel, synchronous, active-high
//   insert_coins   in   coin entry enabled by vm2002 (level)
//   coins[1:0]     in   coin code: 00 none, 01/10/11 = C1/C2/C3
//   done           in   credit consumed by vm2002 (1-cycle pulse)
//   amount[7:0]    out  current credit in cents
//   coin_accept    out  pulse: coin sampled last cycle was added
//   coin_reject    out  pulse: coin sampled last cycle was returned
//   refund         out  pulse: credit returned to customer
//   refund_amount  out  credit returned, nonzero only while refund=1
//   timeout        out  pulse: inactivity timer expired
module vm2002_coin_acceptor #(
  parameter int MAX_AMOUNT     = 255,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int VAL_C1         = 5,
  parameter int VAL_C2         = 10,
  parameter int VAL_C3         = 25
) (
  input  logic       clk,
  input  logic       hrst_n,
  input  logic       srst,
  input  logic       insert_coins,
  input  logic [1:0] coins,
  input  logic       done,
  output logic [7:0] amount,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       refund,
  output logic [7:0] refund_amount,
  output logic       timeout
);

  // Counter must hold values up to TIMEOUT_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REFUND  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       amount_q, amount_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             coin_accept_q, coin_accept_d;
  logic             coin_reject_q, coin_reject_d;
  logic             refund_q, refund_d;
  logic [7:0]       refund_amount_q, refund_amount_d;
  logic             timeout_q, timeout_d;

  logic [7:0]       coin_value;
  logic             coin_present;
  logic [8:0]       sum;
  logic             coin_fits;
  logic             coin_ok;
  logic             expired;

  // Coin decode and the 9-bit sum, so an oversize total is seen as such
  // instead of wrapping back into range.
  always_comb begin
    coin_value = 8'd0;
    unique case (coins)
      2'b01:   coin_value = 8'(VAL_C1);
      2'b10:   coin_value = 8'(VAL_C2);
      2'b11:   coin_value = 8'(VAL_C3);
      default: coin_value = 8'd0;
    endcase
    coin_present = (coins != 2'b00);
    sum          = {1'b0, amount_q} + {1'b0, coin_value};
    coin_fits    = (sum <= 9'(MAX_AMOUNT));
    coin_ok      = insert_coins && coin_present && coin_fits;
    expired      = (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Next-state and output logic. The idle counter defaults to clear, so it
  // only survives in COLLECT cycles that neither accept a coin nor leave.
  // Expiry is suppressed by an accepted coin in the same cycle.
  always_comb begin
    state_d         = state_q;
    amount_d        = amount_q;
    idle_cnt_d      = '0;
    coin_accept_d   = 1'b0;
    coin_reject_d   = 1'b0;
    refund_d        = 1'b0;
    refund_amount_d = 8'd0;
    timeout_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        amount_d      = 8'd0;
        coin_reject_d = coin_present;
        if (insert_coins) begin
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (srst) begin
          coin_reject_d = coin_present;
          state_d       = (amount_q != 8'd0) ? REFUND : IDLE;
        end else if (done) begin
          coin_reject_d = coin_present;
          amount_d      = 8'd0;
          state_d       = IDLE;
        end else if (expired && !coin_ok) begin
          timeout_d     = 1'b1;
          coin_reject_d = coin_present;
          state_d       = (amount_q != 8'd0) ? REFUND : IDLE;
        end else if (coin_ok) begin
          coin_accept_d = 1'b1;
          amount_d      = sum[7:0];
        end else begin
          coin_reject_d = coin_present;
          idle_cnt_d    = idle_cnt_q + CNT_W'(1);
        end
      end

      // The credit is still held in amount_q here; it is moved onto
      // refund_amount and cleared in one step.
      REFUND: begin
        refund_d        = 1'b1;
        refund_amount_d = amount_q;
        amount_d        = 8'd0;
        coin_reject_d   = coin_present;
        state_d         = IDLE;
      end

      default: begin
        amount_d = 8'd0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers; hard reset drops any held credit silently.
  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q         <= IDLE;
      amount_q        <= 8'd0;
      idle_cnt_q      <= '0;
      coin_accept_q   <= 1'b0;
      coin_reject_q   <= 1'b0;
      refund_q        <= 1'b0;
      refund_amount_q <= 8'd0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      amount_q        <= amount_d;
      idle_cnt_q      <= idle_cnt_d;
      coin_accept_q   <= coin_accept_d;
      coin_reject_q   <= coin_reject_d;
      refund_q        <= refund_d;
      refund_amount_q <= refund_amount_d;
      timeout_q       <= timeout_d;
    end
  end

  assign amount        = amount_q;
  assign coin_accept   = coin_accept_q;
  assign coin_reject   = coin_reject_q;
  assign refund        = refund_q;
  assign refund_amount = refund_amount_q;
  assign timeout       = timeout_q;

endmodule
